// File: rtl/ddr_cmd_arb.sv
// Round-robin arbiter sharing the DDR controller command port; each grant is held until cmd_done.
// Optional watchdog enabled by defining DDR_ARB_TIMEOUT_EN (otherwise tmo_err is constant 0).
module ddr_cmd_arb #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 25,
    parameter int LEN_W  = 4,
    parameter int TMO_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_done,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [NREQ-1:0]          gnt,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     cmd_we,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [LEN_W-1:0]         cmd_len,
    input  logic                     cmd_done,
    output logic                     busy,
    output logic                     tmo_err
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t              state_r, state_next;
    logic [PTR_W-1:0]    ptr_r, ptr_next;
    logic [PTR_W-1:0]    win_r, win_next;
    logic [NREQ-1:0]     gnt_r, gnt_next;
    logic                cmd_valid_r, cmd_valid_next;
    logic                cmd_we_r, cmd_we_next;
    logic [ADDR_W-1:0]   cmd_addr_r, cmd_addr_next;
    logic [LEN_W-1:0]    cmd_len_r, cmd_len_next;
    logic                busy_r, busy_next;
    logic                tmo_err_r, tmo_err_next;
    logic                found_s;
    logic [PTR_W-1:0]    pick_s;
    logic [PTR_W-1:0]    idx_s;
    int                  sum_s;

`ifdef DDR_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    logic [TMO_W-1:0]    tmo_cnt_r, tmo_cnt_next;
`endif

    // Successor of a requester index, wrapping at NREQ.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        if (int'(idx) == NREQ - 1) begin
            return {PTR_W{1'b0}};
        end else begin
            return idx + PTR_ONE;
        end
    endfunction

    // Round-robin search: first active request at or after ptr.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {PTR_W{1'b0}};
        idx_s   = {PTR_W{1'b0}};
        sum_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = int'(ptr_r) + k;
            if (sum_s >= NREQ) begin
                sum_s = sum_s - NREQ;
            end else begin
                sum_s = sum_s;
            end
            idx_s = PTR_W'(sum_s);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_next     = state_r;
        ptr_next       = ptr_r;
        win_next       = win_r;
        gnt_next       = gnt_r;
        cmd_valid_next = cmd_valid_r;
        cmd_we_next    = cmd_we_r;
        cmd_addr_next  = cmd_addr_r;
        cmd_len_next   = cmd_len_r;
        tmo_err_next   = tmo_err_r;
        case (state_r)
            ST_INIT: begin
                if (init_done) begin
                    state_next = ST_ARB;
                end else begin
                    state_next = ST_INIT;
                end
            end
            ST_ARB: begin
                if (found_s) begin
                    win_next           = pick_s;
                    gnt_next           = {NREQ{1'b0}};
                    gnt_next[pick_s]   = 1'b1;
                    cmd_valid_next     = 1'b1;
                    cmd_we_next        = req_we[pick_s];
                    cmd_addr_next      = req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
                    cmd_len_next       = req_len[int'(pick_s)*LEN_W +: LEN_W];
                    state_next         = ST_ISSUE;
                end else begin
                    state_next = ST_ARB;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_next = 1'b0;
                    state_next     = ST_WAIT;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    gnt_next   = {NREQ{1'b0}};
                    ptr_next   = wrap_inc(win_r);
                    state_next = ST_ARB;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            default: begin
                state_next     = ST_INIT;
                gnt_next       = {NREQ{1'b0}};
                cmd_valid_next = 1'b0;
            end
        endcase

`ifdef DDR_ARB_TIMEOUT_EN
        // Watchdog overrides normal progress once the counter saturates.
        tmo_cnt_next = tmo_cnt_r;
        if (state_r == ST_ARB) begin
            tmo_cnt_next = {TMO_W{1'b0}};
        end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
            if (&tmo_cnt_r) begin
                tmo_err_next   = 1'b1;
                gnt_next       = {NREQ{1'b0}};
                cmd_valid_next = 1'b0;
                ptr_next       = wrap_inc(win_r);
                state_next     = ST_ARB;
            end else begin
                tmo_cnt_next = tmo_cnt_r + TMO_ONE;
            end
        end else begin
            tmo_cnt_next = tmo_cnt_r;
        end
`else
        tmo_err_next = 1'b0;
`endif

        busy_next = (state_next != ST_ARB);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            ptr_r       <= {PTR_W{1'b0}};
            win_r       <= {PTR_W{1'b0}};
            gnt_r       <= {NREQ{1'b0}};
            cmd_valid_r <= 1'b0;
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_len_r   <= {LEN_W{1'b0}};
            busy_r      <= 1'b1;
            tmo_err_r   <= 1'b0;
        end else begin
            state_r     <= state_next;
            ptr_r       <= ptr_next;
            win_r       <= win_next;
            gnt_r       <= gnt_next;
            cmd_valid_r <= cmd_valid_next;
            cmd_we_r    <= cmd_we_next;
            cmd_addr_r  <= cmd_addr_next;
            cmd_len_r   <= cmd_len_next;
            busy_r      <= busy_next;
            tmo_err_r   <= tmo_err_next;
        end
    end

`ifdef DDR_ARB_TIMEOUT_EN
    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_next;
        end
    end
`endif

    assign gnt       = gnt_r;
    assign cmd_valid = cmd_valid_r;
    assign cmd_we    = cmd_we_r;
    assign cmd_addr  = cmd_addr_r;
    assign cmd_len   = cmd_len_r;
    assign busy      = busy_r;
    assign tmo_err   = tmo_err_r;

endmodule

// File: doc/ddr_cmd_arb.md
# ddr_cmd_arb

Round-robin arbiter that shares the single command port of the DDR controller among up to four requesters: PCI target window, DMA read, DMA write and refresh/scrub housekeeping. It sits in `top` between the `i_user` request sources and `i_ddr.ddr_controller0`. It holds every grant for one whole burst, until the controller signals completion, and it issues nothing until controller initialisation is done.

## Interface
- `NREQ`, 4: number of requesters, range 2..4.
- `ADDR_W`, 25: DDR word address width.
- `LEN_W`, 4: burst length field width, in beats minus 1.
- `TMO_W`, 10: watchdog counter width. Used only with `DDR_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: arbiter clock, same as the DDR controller user clock.
- `rst` in 1: synchronous, active-high reset.
- `init_done` in 1: DDR controller initialisation complete (level).
- `req` in NREQ: request per requester. Held high until granted and done.
- `req_we` in NREQ: 1 = write burst, 0 = read burst.
- `req_addr` in NREQ*ADDR_W: packed start address. Requester i uses slice i.
- `req_len` in NREQ*LEN_W: packed burst length minus 1.
- `gnt` out NREQ: one-hot grant. Held from issue through completion.
- `cmd_valid` out 1: command to controller.
- `cmd_ready` in 1: controller accepts the command when both valid and ready are high.
- `cmd_we`, `cmd_addr`, `cmd_len` out 1/ADDR_W/LEN_W: muxed command fields.
- `cmd_done` in 1: single-cycle pulse when the burst has finished.
- `busy` out 1: arbiter is not in ARB.
- `tmo_err` out 1: sticky watchdog error. Tied to 0 without the macro.

## Operation
- FSM states: INIT → ARB → ISSUE → WAIT → ARB.
- INIT: stay here while `init_done`=0. Move to ARB on the first cycle `init_done`=1. `init_done` falling later is ignored.
- ARB: if any `req` bit is high, choose the winner by round-robin.
  - Search starts at `ptr`, then `ptr`+1 … wrapping modulo NREQ.
  - Register `gnt`, latch the winner's `we`/`addr`/`len` into command registers, go to ISSUE.
  - With no request, stay in ARB.
- ISSUE: `cmd_valid`=1 with the latched fields. When `cmd_ready`=1, drop `cmd_valid` next cycle and go to WAIT.
- WAIT: when `cmd_done`=1, clear `gnt`, set `ptr` = winner+1 mod NREQ, go to ARB.
- Requester inputs are sampled only in ARB. Changing them after grant has no effect on the issued command.
- A requester that drops `req` while granted still completes its burst; the grant is not withdrawn.
- A `cmd_done` pulse outside WAIT is ignored.
- `cmd_ready` seen while `cmd_valid`=0 is ignored.
- Reset values:
  - state INIT, `ptr`=0, `gnt`=0.
  - `cmd_valid`=0, `cmd_we`=0, `cmd_addr`=0, `cmd_len`=0.
  - `busy`=1 (INIT counts as busy), `tmo_err`=0.
- `rst` asserted in any state forces all of the above on the next edge, mid-burst included. Stranded controller state is the controller's problem.

## Timing
- Request-to-command latency: a `req` rising in cycle N (state ARB) gives `gnt` and `cmd_valid` high in cycle N+1.
- Back-to-back bursts: `cmd_done` in cycle M gives `gnt`=0 in M+1 (ARB). The next grant follows in M+2. The minimum gap is one idle cycle.
- Single-cycle handshake: if `cmd_ready` is already high when `cmd_valid` rises, ISSUE lasts exactly one cycle.
- `cmd_done` in the same cycle as the command handshake is not possible by controller contract. It is not handled.

## Configuration
- `DDR_ARB_TIMEOUT_EN` defined:
  - A `TMO_W`-bit counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - At all-ones it sets `tmo_err`, clears `gnt` and `cmd_valid`, advances `ptr` and returns to ARB.
  - `tmo_err` clears only on `rst`.
- Undefined: no counter. ISSUE/WAIT wait indefinitely. `tmo_err` is a constant 0.

## Test plan
- Init gating: `req`=4'b0001 with `init_done`=0 for 50 cycles → `gnt`=0 and `cmd_valid`=0. Raise `init_done` → `gnt`=0001 two cycles later.
- Single write: req0, we=1, addr=0x0000100, len=3; `cmd_ready` high → one `cmd_valid` cycle with those fields. `gnt`=0001 holds until `cmd_done`, and clears the cycle after.
- Round-robin fairness: all four `req` held high, each burst acked and done after 5 cycles → grant order 0,1,2,3,0,1. No requester is granted twice before the others.
- Backpressure: `cmd_ready` low for 7 cycles → `cmd_valid` and fields stay stable for 8 cycles. Exactly one acceptance.
- Mid-burst reset: assert `rst` in WAIT → next cycle state INIT, `gnt`=0, `ptr`=0, `busy`=1. A stray `cmd_done` afterwards is ignored.
- With `DDR_ARB_TIMEOUT_EN` and `TMO_W`=4: no `cmd_done` after the grant → `tmo_err`=1 and `gnt`=0 16 cycles after ISSUE entry. The next pending requester is then granted.
